// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating counters indexed by low PC bits,
// filled by an init sweep after reset. Optional statistics under BP_STATS_EN.
module branch_predictor #(
  parameter int         IDX_W    = 4,
  parameter int         PC_W     = 10,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] FETCH_PC,
  input  logic [3:0]      FETCH_BRANCH_TYPE,
  output logic            BRANCH_PREDICTED,
  output logic            READY,
  input  logic            RES_VALID,
  input  logic [PC_W-1:0] RES_PC,
  input  logic [3:0]      RES_BRANCH_TYPE,
  input  logic            RES_TAKEN,
  input  logic            RES_MISS,
  output logic [15:0]     STAT_RESOLVED,
  output logic [15:0]     STAT_MISSES
);

  localparam int              DEPTH    = 2**IDX_W;
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_ready, w_ready_nxt;
  logic [1:0]       r_table [DEPTH];

  logic             w_tbl_we;
  logic [IDX_W-1:0] w_tbl_addr;
  logic [1:0]       w_tbl_wdata;
  logic             w_res_is_cond;
  logic [1:0]       w_fetch_ctr;
  logic             w_pred;
  logic             w_unused;

  function automatic logic is_cond(input logic [3:0] t);
    logic v;
    case (t)
      4'h1, 4'h2, 4'h3, 4'h5: v = 1'b1;
      default:                v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic is_static_taken(input logic [3:0] t);
    logic v;
    case (t)
      4'h4, 4'h6, 4'h7, 4'h8, 4'h9: v = 1'b1;
      default:                      v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] v;
    if (taken) begin
      if (ctr == 2'b11) v = 2'b11;
      else              v = ctr + 2'b01;
    end else begin
      if (ctr == 2'b00) v = 2'b00;
      else              v = ctr - 2'b01;
    end
    return v;
  endfunction

  assign w_res_is_cond = RES_VALID && is_cond(RES_BRANCH_TYPE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // The single table write port is shared by the init sweep and training.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = r_ready;
    w_tbl_we    = 1'b0;
    w_tbl_addr  = r_ptr;
    w_tbl_wdata = INIT_CTR;
    case (r_state)
      S_INIT: begin
        w_tbl_we  = 1'b1;
        w_ptr_nxt = r_ptr + IDX_W'(1);
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = S_RUN;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = S_INIT;
          w_ready_nxt = 1'b0;
        end
      end
      S_RUN: begin
        w_ready_nxt = 1'b1;
        if (w_res_is_cond) begin
          w_tbl_we    = 1'b1;
          w_tbl_addr  = RES_PC[IDX_W-1:0];
          w_tbl_wdata = sat_step(r_table[RES_PC[IDX_W-1:0]], RES_TAKEN);
        end else begin
          w_tbl_we    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_ptr_nxt   = '0;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // No reset on the array so it can map to distributed RAM.
  always_ff @(posedge CLK) begin
    if (w_tbl_we && !RST) begin
      r_table[w_tbl_addr] <= w_tbl_wdata;
    end
  end

  always_comb begin
    w_fetch_ctr = r_table[FETCH_PC[IDX_W-1:0]];
    if (is_static_taken(FETCH_BRANCH_TYPE)) begin
      w_pred = 1'b1;
    end else if (is_cond(FETCH_BRANCH_TYPE) && (r_state == S_RUN)) begin
      w_pred = w_fetch_ctr[1];
    end else begin
      w_pred = 1'b0;
    end
  end

  assign BRANCH_PREDICTED = w_pred;
  assign READY            = r_ready;
  assign w_unused         = ^{FETCH_PC[PC_W-1:IDX_W], RES_PC[PC_W-1:IDX_W], RES_MISS};

`ifdef BP_STATS_EN
  logic [15:0] r_stat_resolved;
  logic [15:0] r_stat_misses;
  logic        w_run_res;

  assign w_run_res = (r_state == S_RUN) && RES_VALID;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stat_resolved <= 16'h0000;
      r_stat_misses   <= 16'h0000;
    end else begin
      if (w_run_res && is_cond(RES_BRANCH_TYPE) && (r_stat_resolved != 16'hFFFF)) begin
        r_stat_resolved <= r_stat_resolved + 16'h0001;
      end
      if (w_run_res && RES_MISS && (r_stat_misses != 16'hFFFF)) begin
        r_stat_misses <= r_stat_misses + 16'h0001;
      end
    end
  end

  assign STAT_RESOLVED = r_stat_resolved;
  assign STAT_MISSES   = r_stat_misses;
`else
  assign STAT_RESOLVED = 16'h0000;
  assign STAT_MISSES   = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: expectations are queued when stimulus
// is driven and popped when the outputs are sampled on the falling edge.
module tb_branch_predictor;

  localparam int          PC_W         = 10;
  localparam logic [15:0] STATIC_TAKEN = 16'h03D0;

  logic            CLK = 1'b0;
  logic            RST;
  logic [PC_W-1:0] FETCH_PC;
  logic [3:0]      FETCH_BRANCH_TYPE;
  logic            BRANCH_PREDICTED;
  logic            READY;
  logic            RES_VALID;
  logic [PC_W-1:0] RES_PC;
  logic [3:0]      RES_BRANCH_TYPE;
  logic            RES_TAKEN;
  logic            RES_MISS;
  logic [15:0]     STAT_RESOLVED;
  logic [15:0]     STAT_MISSES;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  always #5 CLK = ~CLK;

  branch_predictor #(.IDX_W(4), .PC_W(10), .INIT_CTR(2'b01)) dut (
    .CLK(CLK), .RST(RST),
    .FETCH_PC(FETCH_PC), .FETCH_BRANCH_TYPE(FETCH_BRANCH_TYPE),
    .BRANCH_PREDICTED(BRANCH_PREDICTED), .READY(READY),
    .RES_VALID(RES_VALID), .RES_PC(RES_PC), .RES_BRANCH_TYPE(RES_BRANCH_TYPE),
    .RES_TAKEN(RES_TAKEN), .RES_MISS(RES_MISS),
    .STAT_RESOLVED(STAT_RESOLVED), .STAT_MISSES(STAT_MISSES)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_res();
    RES_VALID       = 1'b0;
    RES_PC          = 10'h000;
    RES_BRANCH_TYPE = 4'h0;
    RES_TAKEN       = 1'b0;
    RES_MISS        = 1'b0;
  endtask

  task automatic resolve(input logic [9:0] pc, input logic [3:0] t,
                         input logic tk, input logic ms);
    RES_VALID = 1'b1; RES_PC = pc; RES_BRANCH_TYPE = t;
    RES_TAKEN = tk;   RES_MISS = ms;
    tick();
    idle_res();
  endtask

  task automatic reset_and_sweep();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    logic [15:0] st;
    logic [3:0]  t;
    st = STATIC_TAKEN;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      t = 4'(c - 1);
      FETCH_PC = 10'(c * 37);
      FETCH_BRANCH_TYPE = t;
      exp_q.push_back(16'h0000);
      exp_q.push_back({15'h0000, st[t]});
      @(negedge CLK);
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, READY} !== exp_v) begin
        n_err++; $display("FAIL ready_init cycle=%0d got %0b exp %0b", c, READY, exp_v[0]);
      end
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
        n_err++; $display("FAIL pred_init type=%0h got %0b exp %0b", t, BRANCH_PREDICTED, exp_v[0]);
      end
      tick();
    end
    exp_q.push_back(16'h0001);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, READY} !== exp_v) begin
      n_err++; $display("FAIL ready_cycle17 got %0b exp %0b", READY, exp_v[0]);
    end
    for (int i = 0; i < 16; i++) begin
      FETCH_PC = 10'(i * 64 + i);
      FETCH_BRANCH_TYPE = 4'h1;
      exp_q.push_back(16'h0000);
      #1;
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
        n_err++; $display("FAIL pred_init_ctr pc=%h got %0b exp %0b", FETCH_PC, BRANCH_PREDICTED, exp_v[0]);
      end
    end
    tick();
  endtask

  task automatic test_static();
    logic [15:0] st;
    logic [3:0]  t;
    st = STATIC_TAKEN;
    for (int i = 0; i < 16; i++) begin
      t = 4'(i);
      FETCH_PC = 10'($urandom_range(0, 1023));
      FETCH_BRANCH_TYPE = t;
      exp_q.push_back({15'h0000, st[t]});
      @(negedge CLK);
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
        n_err++; $display("FAIL pred_static type=%0h got %0b exp %0b", t, BRANCH_PREDICTED, exp_v[0]);
      end
      tick();
    end
  endtask

  task automatic test_training();
    bit tk_pat[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit pr_pat[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    FETCH_PC = 10'h023;
    FETCH_BRANCH_TYPE = 4'h3;
    for (int i = 0; i < 9; i++) begin
      resolve(10'h023, 4'h3, tk_pat[i], 1'b0);
      exp_q.push_back({15'h0000, pr_pat[i]});
      @(negedge CLK);
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
        n_err++; $display("FAIL train step=%0d got %0b exp %0b", i, BRANCH_PREDICTED, exp_v[0]);
      end
    end
    tick();
  endtask

  task automatic test_same_cycle();
    FETCH_PC = 10'h005;
    FETCH_BRANCH_TYPE = 4'h5;
    RES_VALID = 1'b1; RES_PC = 10'h005; RES_BRANCH_TYPE = 4'h5;
    RES_TAKEN = 1'b1; RES_MISS = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
      n_err++; $display("FAIL hazard_same got %0b exp %0b", BRANCH_PREDICTED, exp_v[0]);
    end
    tick();
    idle_res();
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
      n_err++; $display("FAIL hazard_next got %0b exp %0b", BRANCH_PREDICTED, exp_v[0]);
    end
    tick();
  endtask

  task automatic test_alias_ignore();
    logic [3:0] nc_types[4] = '{4'h6, 4'h0, 4'h7, 4'hC};
    reset_and_sweep();
    FETCH_PC = 10'h003;
    FETCH_BRANCH_TYPE = 4'h2;
    resolve(10'h013, 4'h1, 1'b1, 1'b0);
    resolve(10'h013, 4'h1, 1'b1, 1'b0);
    exp_q.push_back(16'h0001);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
      n_err++; $display("FAIL alias got %0b exp %0b", BRANCH_PREDICTED, exp_v[0]);
    end
    // Counter is at 11; two counted decrements would drop it to 01.
    for (int i = 0; i < 4; i++) begin
      resolve(10'h003, nc_types[i], 1'b0, 1'b1);
      exp_q.push_back(16'h0001);
      @(negedge CLK);
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
        n_err++; $display("FAIL ignore_type=%0h got %0b exp %0b", nc_types[i], BRANCH_PREDICTED, exp_v[0]);
      end
    end
    resolve(10'h003, 4'h2, 1'b0, 1'b1);
    exp_q.push_back(16'h0001);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
      n_err++; $display("FAIL alias_dec1 got %0b exp %0b", BRANCH_PREDICTED, exp_v[0]);
    end
    tick();
  endtask

  task automatic test_mid_sweep_stats();
    logic [15:0] exp_res, exp_mis;
`ifdef BP_STATS_EN
    exp_res = 16'd3; exp_mis = 16'd2;
`else
    exp_res = 16'd0; exp_mis = 16'd0;
`endif
    FETCH_PC = 10'h000;
    FETCH_BRANCH_TYPE = 4'h0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    RES_VALID = 1'b1; RES_PC = 10'h000; RES_BRANCH_TYPE = 4'h1;
    RES_TAKEN = 1'b1; RES_MISS = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      RST = (c == 7) ? 1'b1 : 1'b0;
      exp_q.push_back(16'h0000);
      @(negedge CLK);
      exp_v = exp_q.pop_front(); n_vec++;
      if ({15'h0000, READY} !== exp_v) begin
        n_err++; $display("FAIL ready_midsweep cycle=%0d got %0b exp %0b", c, READY, exp_v[0]);
      end
      tick();
    end
    RST = 1'b0;
    idle_res();
    FETCH_BRANCH_TYPE = 4'h1;
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, READY} !== exp_v) begin
      n_err++; $display("FAIL ready_after_restart got %0b exp %0b", READY, exp_v[0]);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, BRANCH_PREDICTED} !== exp_v) begin
      n_err++; $display("FAIL init_res_ignored got %0b exp %0b", BRANCH_PREDICTED, exp_v[0]);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_RESOLVED !== exp_v) begin
      n_err++; $display("FAIL stat_res_init got %h exp %h", STAT_RESOLVED, exp_v);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_MISSES !== exp_v) begin
      n_err++; $display("FAIL stat_mis_init got %h exp %h", STAT_MISSES, exp_v);
    end
    tick();
    resolve(10'h031, 4'h1, 1'b1, 1'b1);
    resolve(10'h032, 4'h2, 1'b0, 1'b0);
    resolve(10'h035, 4'h5, 1'b1, 1'b1);
    resolve(10'h036, 4'h7, 1'b1, 1'b0);
    exp_q.push_back(exp_res);
    exp_q.push_back(exp_mis);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_RESOLVED !== exp_v) begin
      n_err++; $display("FAIL stat_resolved got %h exp %h", STAT_RESOLVED, exp_v);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_MISSES !== exp_v) begin
      n_err++; $display("FAIL stat_misses got %h exp %h", STAT_MISSES, exp_v);
    end
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    @(negedge CLK);
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_RESOLVED !== exp_v) begin
      n_err++; $display("FAIL stat_res_clear got %h exp %h", STAT_RESOLVED, exp_v);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if (STAT_MISSES !== exp_v) begin
      n_err++; $display("FAIL stat_mis_clear got %h exp %h", STAT_MISSES, exp_v);
    end
    exp_v = exp_q.pop_front(); n_vec++;
    if ({15'h0000, READY} !== exp_v) begin
      n_err++; $display("FAIL ready_clear got %0b exp %0b", READY, exp_v[0]);
    end
    tick();
  endtask

  initial begin
    RST = 1'b1;
    FETCH_PC = 10'h000;
    FETCH_BRANCH_TYPE = 4'h0;
    idle_res();
    repeat (2) tick();
    test_reset();
    test_static();
    test_training();
    test_same_cycle();
    test_alias_ignore();
    test_mid_sweep_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart of the execute-stage branch resolver in the RAT pipeline.
- Produces the branch_predicted bit that travels down the pipe with each instruction.
- Is trained by the resolved outcome (taken/miss) returned from execute.
- Holds a table of 2-bit saturating counters indexed by low PC bits. Runs a reset sweep FSM so the table maps to distributed RAM.

Parameters:
- IDX_W, 4, index width; table has 2**IDX_W entries, indexed by PC[IDX_W-1:0].
- PC_W, 10, program counter width.
- INIT_CTR, 2'b01, counter value written at init (weakly not taken).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- FETCH_PC  in  PC_W  PC of the instruction in fetch.
- FETCH_BRANCH_TYPE  in  4  pre-decoded type: 0 none, 1 BRCC, 2 BRCS, 3 BREQ, 4 BRN, 5 BRNE, 6 CALL, 7 RET, 8 RETID, 9 RETIE, A-F unused.
- BRANCH_PREDICTED  out  1  prediction for the fetch instruction (combinational from FETCH_* and table).
- READY  out  1  1 once the init sweep has completed.
- RES_VALID  in  1  resolve strobe from execute, one cycle per resolved instruction.
- RES_PC  in  PC_W  PC of the resolved instruction.
- RES_BRANCH_TYPE  in  4  type of the resolved instruction.
- RES_TAKEN  in  1  actual outcome (BRANCH_TAKEN from execute).
- RES_MISS  in  1  prediction miss flag from execute.
- STAT_RESOLVED  out  16  conditional branches resolved (feature only).
- STAT_MISSES  out  16  misses resolved (feature only).

Behaviour:
- States: INIT, RUN.
- RST=1 at a clock edge: state<=INIT, sweep pointer<=0, READY<=0, stat counters<=0. Table contents are not reset directly.
- INIT:
  - Each cycle writes INIT_CTR to entry [ptr] and increments ptr.
  - At ptr==2**IDX_W-1 the write completes and the state goes to RUN.
  - The sweep takes exactly 2**IDX_W cycles after RST deasserts; READY=1 from the following cycle.
  - During INIT, RES_VALID is ignored and BRANCH_PREDICTED follows the static rules only, with conditional types predicted 0.
- RST asserted mid-sweep or in RUN restarts INIT from ptr 0.
- Prediction (0-cycle latency, no registers in the path):
  - Types 4,6,7,8,9 → 1.
  - Types 1,2,3,5 → MSB of table[FETCH_PC[IDX_W-1:0]] (RUN state).
  - Type 0 and A-F → 0.
- Update (RUN only): when RES_VALID=1 and RES_BRANCH_TYPE is in {1,2,3,5}, entry [RES_PC[IDX_W-1:0]] is written at the clock edge.
  - RES_TAKEN=1: +1, saturating at 3.
  - RES_TAKEN=0: -1, saturating at 0.
- Non-conditional types never modify the table.
- Write-to-read: a lookup of the same index in the cycle of an update returns the pre-update value. The new value is visible the next cycle; there is no bypass.
- Aliasing: PCs equal modulo 2**IDX_W share an entry, by design.
- RES_MISS does not affect the table (RES_TAKEN alone trains); it is used only by statistics.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - STAT_RESOLVED increments on each RUN-state RES_VALID with a conditional type.
  - STAT_MISSES increments on each RUN-state RES_VALID with RES_MISS=1, any type.
  - Both saturate at 16'hFFFF and clear on RST.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset: pulse RST 1 cycle → READY=0 for 16 cycles, READY=1 on cycle 17. Then FETCH_BRANCH_TYPE=1 at any PC → BRANCH_PREDICTED=0 (counter 01).
- Static types: FETCH_BRANCH_TYPE=4,6,7,8,9 → BRANCH_PREDICTED=1; types 0 and 'hC → 0, including during INIT.
- Training:
  - Two RES_VALID updates at PC=10'h023, type 3, RES_TAKEN=1 → fetch PC=10'h023 type 3 predicts 1 (counter 11).
  - A third taken update leaves the counter at 11.
  - One not-taken update → still 1 (counter 10).
  - Second not-taken update → 0.
- Same-cycle hazard: update index 5 from 01 toward taken while fetching PC=10'h005 type 5 in the same cycle → predicts 0 that cycle, 1 the next cycle (counter 10).
- Aliasing/ignores:
  - Train PC=10'h013 taken twice → fetch PC=10'h003 type 2 predicts 1.
  - RES_VALID with type 6 and RES_TAKEN=0 leaves the table unchanged.
- Mid-sweep reset (BP_STATS_EN defined):
  - Assert RST at sweep cycle 7 → READY stays 0 for a full 16 further cycles.
  - 3 conditional resolves, 2 with RES_MISS=1 → STAT_RESOLVED=3, STAT_MISSES=2.
  - Next RST → both read 0.
